// File: rtl/scroll_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// scroll_sequencer
//
// Game-level controller for the scroll datapath. It runs the play state
// machine (IDLE -> RUN -> DYING -> OVER). It gates scrolling through halt and
// pulses game_rst when a game starts. From the score it derives the
// difficulty level and the speed offset.
//
// Ports
//   clk           system clock
//   sys_rst       asynchronous active-high reset
//   frame_tick    one-cycle pulse per video frame
//   btn_move      debounced move button (level)
//   btn_start     debounced start button (level); a rising edge starts a game
//   collision     car/player overlap, sampled every cycle
//   halt          freezes the scroll block when high
//   game_rst      one-cycle pulse that restarts the scroll block
//   move_amt      pixels per frame while moving (constant MOVE_AMT)
//   speed_change  per-level speed offset handed to the scroll block
//   score         rows travelled in the current/last game
//   level         current difficulty level
//   high_score    best score since sys_rst
//   state         00 IDLE, 01 RUN, 10 DYING, 11 OVER
// -----------------------------------------------------------------------------
module scroll_sequencer #(
   parameter int MOVE_AMT     = 8,
   parameter int ROW_PX       = 32,
   parameter int LEVEL_ROWS   = 16,
   parameter int SPEED_STEP   = 12,
   parameter int MAX_LEVEL    = 15,
   parameter int DEATH_FRAMES = 60
) (
   input  logic       clk,
   input  logic       sys_rst,
   input  logic       frame_tick,
   input  logic       btn_move,
   input  logic       btn_start,
   input  logic       collision,
   output logic       halt,
   output logic       game_rst,
   output logic [7:0] move_amt,
   output logic [7:0] speed_change,
   output logic [9:0] score,
   output logic [3:0] level,
   output logic [9:0] high_score,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DYING = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   localparam int              DW         = $clog2(DEATH_FRAMES + 1);
   localparam logic [6:0]      MOVE_AMT7  = 7'(MOVE_AMT);
   localparam logic [6:0]      ROW_PX7    = 7'(ROW_PX);
   localparam logic [9:0]      SCORE_MAX  = 10'd1023;
   localparam logic [3:0]      LEVEL_MAX  = 4'(MAX_LEVEL);
   localparam logic [DW-1:0]   DEATH_LAST = DW'(DEATH_FRAMES - 1);

   state_t        state_reg, state_next;
   logic          start_prev_reg;
   logic          game_rst_reg, game_rst_next;
   logic [6:0]    dist_reg, dist_next;
   logic [9:0]    score_reg, score_next;
   logic [3:0]    level_reg, level_next;
   logic [9:0]    high_score_reg, high_score_next;
   logic [7:0]    speed_reg, speed_next;
   logic [DW-1:0] death_cnt_reg, death_cnt_next;

   logic          start_edge;
   logic [6:0]    dist_sum;
   logic [9:0]    score_plus;
   logic [11:0]   speed_full;
   logic [7:0]    speed_sat;

   assign start_edge = btn_start & ~start_prev_reg;
   assign dist_sum   = dist_reg + MOVE_AMT7;
   assign score_plus = score_reg + 10'd1;

   // speed_change tracks level one cycle later, clamped to 8 bits.
   assign speed_full = 12'(level_reg) * 12'(SPEED_STEP);
   assign speed_sat  = (speed_full > 12'd255) ? 8'hFF : speed_full[7:0];

   always_comb begin
      state_next      = state_reg;
      game_rst_next   = 1'b0;
      dist_next       = dist_reg;
      score_next      = score_reg;
      level_next      = level_reg;
      high_score_next = high_score_reg;
      speed_next      = speed_sat;
      death_cnt_next  = death_cnt_reg;
      halt            = 1'b1;

      case (state_reg)
         ST_IDLE, ST_OVER: begin
            if (start_edge) begin
               game_rst_next = 1'b1;
               score_next    = '0;
               level_next    = '0;
               dist_next     = '0;
               speed_next    = '0;
               state_next    = ST_RUN;
            end
         end

         ST_RUN: begin
            halt = ~btn_move;
            // Collision wins over a same-cycle frame: no travel is credited.
            if (collision) begin
               state_next     = ST_DYING;
               death_cnt_next = '0;
            end else if (frame_tick && btn_move) begin
               if (dist_sum >= ROW_PX7) begin
                  dist_next = dist_sum - ROW_PX7;
                  if (score_reg != SCORE_MAX) begin
                     score_next = score_plus;
                     if (((score_plus % 10'(LEVEL_ROWS)) == 10'd0) &&
                         (level_reg != LEVEL_MAX)) begin
                        level_next = level_reg + 4'd1;
                     end
                  end
               end else begin
                  dist_next = dist_sum;
               end
            end
         end

         ST_DYING: begin
            if (frame_tick) begin
               if (death_cnt_reg == DEATH_LAST) begin
                  state_next = ST_OVER;
                  if (score_reg > high_score_reg) begin
                     high_score_next = score_reg;
                  end
               end else begin
                  death_cnt_next = death_cnt_reg + 1'b1;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_reg      <= ST_IDLE;
         start_prev_reg <= 1'b0;
         game_rst_reg   <= 1'b0;
         dist_reg       <= '0;
         score_reg      <= '0;
         level_reg      <= '0;
         high_score_reg <= '0;
         speed_reg      <= '0;
         death_cnt_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         start_prev_reg <= btn_start;
         game_rst_reg   <= game_rst_next;
         dist_reg       <= dist_next;
         score_reg      <= score_next;
         level_reg      <= level_next;
         high_score_reg <= high_score_next;
         speed_reg      <= speed_next;
         death_cnt_reg  <= death_cnt_next;
      end
   end

   assign game_rst     = game_rst_reg;
   assign move_amt     = 8'(MOVE_AMT);
   assign speed_change = speed_reg;
   assign score        = score_reg;
   assign level        = level_reg;
   assign high_score   = high_score_reg;
   assign state        = state_reg;

endmodule

// File: tb/tb_scroll_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_scroll_sequencer
//
// Directed bench for scroll_sequencer. A behavioural model tracks total
// pixels travelled and derives score/level from it arithmetically. A compare
// process checks every DUT output against the model on each falling edge.
// Hand-computed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_scroll_sequencer;
   localparam int MOVE = 8;
   localparam int ROW  = 32;
   localparam int LR   = 16;
   localparam int STEP = 12;
   localparam int MAXL = 15;
   localparam int DF   = 60;

   logic       clk = 1'b0;
   logic       sys_rst;
   logic       frame_tick, btn_move, btn_start, collision;
   logic       halt, game_rst;
   logic [7:0] move_amt, speed_change;
   logic [9:0] score, high_score;
   logic [3:0] level;
   logic [1:0] state;

   always #5 clk = ~clk;

   scroll_sequencer #(
      .MOVE_AMT(MOVE), .ROW_PX(ROW), .LEVEL_ROWS(LR),
      .SPEED_STEP(STEP), .MAX_LEVEL(MAXL), .DEATH_FRAMES(DF)
   ) dut (
      .clk(clk), .sys_rst(sys_rst), .frame_tick(frame_tick),
      .btn_move(btn_move), .btn_start(btn_start), .collision(collision),
      .halt(halt), .game_rst(game_rst), .move_amt(move_amt),
      .speed_change(speed_change), .score(score), .level(level),
      .high_score(high_score), .state(state)
   );

   int checks = 0;
   int errors = 0;
   bit done   = 1'b0;

   // ---------------- behavioural model ----------------
   // States: 0 IDLE, 1 RUN, 2 DYING, 3 OVER.
   int m_state, m_pix, m_high, m_die, m_speed;
   bit m_prev, m_grst;

   function automatic int m_score();
      int s;
      s = m_pix / ROW;
      return (s > 1023) ? 1023 : s;
   endfunction

   function automatic int m_level();
      int l;
      l = m_score() / LR;
      return (l > MAXL) ? MAXL : l;
   endfunction

   always @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         m_state = 0; m_pix = 0; m_high = 0; m_die = 0; m_speed = 0;
         m_prev = 1'b0; m_grst = 1'b0;
      end else begin
         int spd_n;
         bit grst_n;
         spd_n  = (m_level() * STEP > 255) ? 255 : m_level() * STEP;
         grst_n = 1'b0;
         case (m_state)
            0, 3: if (btn_start && !m_prev) begin
               grst_n = 1'b1; m_pix = 0; spd_n = 0; m_state = 1;
            end
            1: if (collision) begin
               m_state = 2; m_die = 0;
            end else if (frame_tick && btn_move) begin
               m_pix = m_pix + MOVE;
            end
            default: if (frame_tick) begin
               if (m_die == DF - 1) begin
                  m_state = 3;
                  if (m_score() > m_high) m_high = m_score();
               end else begin
                  m_die = m_die + 1;
               end
            end
         endcase
         m_prev  = btn_start;
         m_grst  = grst_n;
         m_speed = spd_n;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      while (!done) begin
         @(negedge clk);
         if (!sys_rst && !done) begin
            chk("state",        int'(state),        m_state);
            chk("halt",         int'(halt),         (m_state == 1) ? int'(!btn_move) : 1);
            chk("game_rst",     int'(game_rst),     int'(m_grst));
            chk("move_amt",     int'(move_amt),     MOVE);
            chk("speed_change", int'(speed_change), m_speed);
            chk("score",        int'(score),        m_score());
            chk("level",        int'(level),        m_level());
            chk("high_score",   int'(high_score),   m_high);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ft(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1; step();
         frame_tick = 1'b0; step();
      end
   endtask

   initial begin
      int cnt;
      sys_rst = 1'b1; frame_tick = 1'b0; btn_move = 1'b0;
      btn_start = 1'b0; collision = 1'b0;
      fork
         compare_loop();
      join_none
      repeat (3) step();
      sys_rst = 1'b0;
      step();
      chk("rst_state", int'(state), 0);
      chk("rst_halt",  int'(halt), 1);
      chk("rst_score", int'(score), 0);
      chk("rst_high",  int'(high_score), 0);
      chk("rst_grst",  int'(game_rst), 0);
      $display("reset released: state=%0d halt=%0d", state, halt);

      // 1: start, single game_rst pulse while start is held
      btn_start = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (game_rst) cnt++;
         if (i == 0) begin
            chk("start_grst",  int'(game_rst), 1);
            chk("start_state", int'(state), 1);
            chk("start_score", int'(score), 0);
            chk("start_halt",  int'(halt), 1);
         end
      end
      chk("grst_count", cnt, 1);
      btn_start = 1'b0;
      step();
      $display("start: game_rst pulses=%0d state=%0d", cnt, state);

      // 2: one row takes four frames
      btn_move = 1'b1; #1;
      chk("move_halt", int'(halt), 0);
      ft(4);
      chk("row1_score", int'(score), 1);
      btn_move = 1'b0; #1;
      chk("stop_halt", int'(halt), 1);
      ft(4);
      chk("idle_score", int'(score), 1);
      $display("row test: score=%0d halt=%0d", score, halt);

      // 3: level progression and saturation
      btn_move = 1'b1;
      ft(252);
      chk("lvl4_score", int'(score), 64);
      chk("lvl4_level", int'(level), 4);
      chk("lvl4_speed", int'(speed_change), 48);
      $display("level test: score=%0d level=%0d speed=%0d", score, level, speed_change);
      ft(784);
      chk("sat_score", int'(score), 260);
      chk("sat_level", int'(level), 15);
      chk("sat_speed", int'(speed_change), 180);
      $display("saturation: score=%0d level=%0d speed=%0d", score, level, speed_change);

      // 4: collision wins over the completing frame, then death timer
      ft(3);
      frame_tick = 1'b1; collision = 1'b1; step();
      frame_tick = 1'b0; collision = 1'b0; step();
      chk("coll_score", int'(score), 260);
      chk("coll_state", int'(state), 2);
      btn_start = 1'b1; step(); btn_start = 1'b0; step();
      chk("dying_start_ignored", int'(state), 2);
      collision = 1'b1; step(); collision = 1'b0;
      ft(59);
      chk("dying_59", int'(state), 2);
      ft(1);
      chk("over_state", int'(state), 3);
      chk("over_high", int'(high_score), 260);
      $display("game over: score=%0d high=%0d", score, high_score);

      // 5: collisions ignored in OVER, lower second game keeps high score
      collision = 1'b1; step(); step(); collision = 1'b0;
      chk("over_coll_ignored", int'(state), 3);
      btn_start = 1'b1; step();
      chk("g2_grst",  int'(game_rst), 1);
      chk("g2_score", int'(score), 0);
      chk("g2_level", int'(level), 0);
      chk("g2_speed", int'(speed_change), 0);
      btn_start = 1'b0;
      ft(20);
      chk("g2_rows", int'(score), 5);
      collision = 1'b1; step(); collision = 1'b0; btn_move = 1'b0;
      ft(60);
      chk("g2_state", int'(state), 3);
      chk("g2_high",  int'(high_score), 260);
      $display("second game: score=%0d high=%0d", score, high_score);

      // 6: asynchronous reset in the middle of a game
      btn_start = 1'b1; step(); btn_start = 1'b0;
      btn_move = 1'b1;
      ft(80);
      chk("g3_score", int'(score), 20);
      chk("g3_level", int'(level), 1);
      #1 sys_rst = 1'b1;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_score", int'(score), 0);
      chk("arst_high",  int'(high_score), 0);
      chk("arst_halt",  int'(halt), 1);
      chk("arst_grst",  int'(game_rst), 0);
      chk("arst_level", int'(level), 0);
      $display("async reset: state=%0d score=%0d high=%0d", state, score, high_score);
      step(); step();
      sys_rst = 1'b0;
      btn_move = 1'b0;
      step(); step();
      chk("post_rst_state", int'(state), 0);

      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/scroll_sequencer.md
Name: scroll_sequencer

Overview:
- Game-level controller that sequences the scroll datapath.
- Owns the play state machine (IDLE/RUN/DYING/OVER) and gates scrolling via halt.
- Issues game_rst on game start and drives move_amt/speed_change from a score-driven difficulty level.
- Sits between the debounced button/collision logic and the scroll block; score/level/high_score feed the HUD renderer.

Parameters:
- MOVE_AMT, 8: pixels per frame presented on move_amt while moving.
- ROW_PX, 32: pixels of travel that count as one scored row.
- LEVEL_ROWS, 16: rows per difficulty level.
- SPEED_STEP, 12: speed_change increment per level.
- MAX_LEVEL, 15: level saturation value.
- DEATH_FRAMES, 60: frame_ticks spent in DYING.

Ports:
- clk  input  1  system clock (25 MHz)
- sys_rst  input  1  asynchronous active-high reset
- frame_tick  input  1  one-cycle pulse per video frame
- btn_move  input  1  debounced move button, level
- btn_start  input  1  debounced start button, level
- collision  input  1  car/player overlap, sampled every cycle
- halt  output  1  freezes scroll when high
- game_rst  output  1  one-cycle pulse restarting scroll
- move_amt  output  8  constant MOVE_AMT
- speed_change  output  8  per-level speed offset to scroll
- score  output  10  rows travelled this game
- level  output  4  current difficulty level
- high_score  output  10  best score since sys_rst
- state  output  2  00 IDLE, 01 RUN, 10 DYING, 11 OVER

Behaviour:
- Reset (async, sys_rst=1): state=IDLE, halt=1, game_rst=0, speed_change=0, score=0, level=0, high_score=0, internal dist=0, death counter=0, start edge register=0. move_amt is always MOVE_AMT.
- start_edge: btn_start high this cycle and low the previous cycle (one registered sample).
- IDLE and OVER:
  - On start_edge: game_rst=1 for exactly the next cycle; score, level, dist and speed_change cleared the same edge; state goes to RUN.
  - Otherwise hold. halt=1.
- RUN:
  - halt is combinational: 0 when btn_move=1, else 1.
  - Scoring, on frame_tick with btn_move=1 and collision=0:
    - dist_next = dist + MOVE_AMT, 7-bit.
    - If dist_next >= ROW_PX: dist = dist_next - ROW_PX and score increments, saturating at 1023.
  - Level-up: when a score increment makes score mod LEVEL_ROWS == 0, level increments, saturating at MAX_LEVEL. speed_change = min(level*SPEED_STEP, 255), registered, updated the cycle after level changes.
  - collision=1 in any RUN cycle: state goes to DYING next cycle and the death counter loads 0. Collision has priority over a same-cycle frame_tick, so no score update that cycle.
- DYING:
  - halt=1. Death counter increments on each frame_tick.
  - When the counter reaches DEATH_FRAMES-1 on a frame_tick: state goes to OVER; high_score = score if score > high_score, updated the same edge.
  - btn_start and collision are ignored.
- collision is ignored in IDLE, DYING and OVER.
- game_rst is never asserted by sys_rst. It is a pulse only on the start transition.
- Outputs score, level and high_score are registered and hold in DYING/OVER until the next start.
- sys_rst mid-game returns everything to reset values immediately, including high_score.

Test Plan:
1. Release reset, pulse btn_start 1 cycle -> game_rst high exactly 1 cycle, state=RUN, score=0, halt=1 with btn_move=0; hold btn_start 10 cycles -> only one game_rst.
2. RUN, btn_move=1, 4 frame_ticks (MOVE_AMT=8, ROW_PX=32) -> halt=0, score=1 after 4th tick, dist=0; release btn_move -> halt=1, further ticks leave score=1.
3. RUN, btn_move=1, 64 rows (256 ticks) -> level=4, speed_change=48; continue until level 15 -> level and speed_change stay 15/180.
4. collision and frame_tick asserted the same cycle when a row would complete -> score unchanged, state=DYING; 60 frame_ticks -> state=OVER, high_score=score.
5. Second game scoring lower than the first -> high_score unchanged; collision pulses during OVER -> ignored; btn_start in DYING -> ignored.
6. Assert sys_rst mid-RUN with score=20 -> asynchronously state=IDLE, score=0, high_score=0, halt=1, game_rst=0.
